// File: rtl/mm_ctrl_pkg.sv
// Shared definitions for the matrix-multiply controller: FSM encoding,
// datapath/address widths and the result-address step.
package mm_ctrl_pkg;
  localparam int DATA_W     = 20;
  localparam int RAM_DATA_W = 32;
  localparam int ADDR_W     = 13;
  localparam logic [ADDR_W-1:0] ADDR_STEP = 13'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  // Counter width for a limit; a limit of 1 still needs a 1-bit counter.
  function automatic int cw(input int lim);
    return (lim > 1) ? $clog2(lim) : 1;
  endfunction
endpackage

// File: rtl/mm_idx_cnt.sv
// Nested i/j/k index counter: k steps within an element, j/i step per
// finished element in row-major order.
module mm_idx_cnt import mm_ctrl_pkg::*; #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int K  = 8,
  parameter int IW = cw(M),
  parameter int JW = cw(N),
  parameter int KW = cw(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          k_clr_i,
  input  logic          k_step_i,
  input  logic          e_step_i,
  output logic [IW-1:0] i_o,
  output logic [JW-1:0] j_o,
  output logic [KW-1:0] k_o,
  output logic          i_wrap_o,
  output logic          j_wrap_o,
  output logic          k_wrap_o
);
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;

  assign i_wrap_o = (i_q == IW'(M - 1));
  assign j_wrap_o = (j_q == JW'(N - 1));
  assign k_wrap_o = (k_q == KW'(K - 1));
  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      if (k_clr_i)       k_d = '0;
      else if (k_step_i) k_d = k_wrap_o ? '0 : k_q + 1'b1;
      if (e_step_i) begin
        if (j_wrap_o) begin
          j_d = '0;
          i_d = i_wrap_o ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/mm_ctrl.sv
// Matrix-multiply sequencer: reads A/B operand pairs, steers an external
// MAC and writes each C element to the result RAM in row-major order.
module mm_ctrl import mm_ctrl_pkg::*; #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 8,
  parameter logic [ADDR_W-1:0] B_BASE = 13'd64,
  parameter logic [ADDR_W-1:0] W_BASE = 13'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     a_addr,
  output logic [ADDR_W-1:0]     b_addr,
  output logic                  mac_clr,
  output logic                  mac_en,
  input  logic [DATA_W-1:0]     sum,
  output logic                  web,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [RAM_DATA_W-1:0] dataRAM,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = cw(M);
  localparam int JW = cw(N);
  localparam int KW = cw(K);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mac_en_q;
  logic              cnt_clr, k_clr, k_step, e_step;
  logic [IW-1:0]     i_w;
  logic [JW-1:0]     j_w;
  logic [KW-1:0]     k_w;
  logic              i_wrap, j_wrap, k_wrap;

  mm_idx_cnt #(.M(M), .N(N), .K(K)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .k_clr_i  (k_clr),
    .k_step_i (k_step),
    .e_step_i (e_step),
    .i_o      (i_w),
    .j_o      (j_w),
    .k_o      (k_w),
    .i_wrap_o (i_wrap),
    .j_wrap_o (j_wrap),
    .k_wrap_o (k_wrap)
  );

  assign a_addr  = ADDR_W'(i_w) * ADDR_W'(K) + ADDR_W'(k_w);
  assign b_addr  = B_BASE + ADDR_W'(k_w) * ADDR_W'(N) + ADDR_W'(j_w);
  assign w_addr  = addr_q;
  assign dataRAM = {{(RAM_DATA_W - DATA_W){1'b0}}, sum};
  assign busy    = (state_q != S_IDLE);
  assign mac_en  = mac_en_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    mac_clr = 1'b0;
    web     = 1'b1;
    done    = 1'b0;
    cnt_clr = 1'b0;
    k_clr   = 1'b0;
    k_step  = 1'b0;
    e_step  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          addr_d  = W_BASE;
        end
      end
      S_CLR: begin
        mac_clr = 1'b1;
        k_clr   = 1'b1;
        state_d = S_READ;
      end
      S_READ: begin
        rd_en  = 1'b1;
        k_step = 1'b1;
        if (k_wrap) state_d = S_DRAIN;
      end
      // Last operand pair is still in flight to the MAC here.
      S_DRAIN: state_d = S_WB;
      S_WB: begin
        web     = 1'b0;
        addr_d  = addr_q + ADDR_STEP;
        e_step  = 1'b1;
        state_d = (i_wrap && j_wrap) ? S_FIN : S_CLR;
      end
      S_FIN: begin
        done    = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= W_BASE;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mac_en_q <= rd_en;
    end
  end
endmodule

// File: tb/tb_mm_ctrl.sv
// Scoreboard bench for mm_ctrl: two instances (default and 2x2x2 with a
// wrapping write base) driven by an operand-RAM/MAC model.
module tb_mm_ctrl;
  localparam logic [12:0] WB1 = 13'h1FF8;

  logic clk = 1'b0;
  logic rst;
  logic st[2];
  bit   force_s[2];
  logic rd[2], mclr[2], men[2], web[2], busy[2], done[2];
  logic [12:0] aa[2], ba[2], wa[2];
  logic [19:0] sum[2];
  logic [31:0] dr[2];

  typedef struct {int g; logic [12:0] a; logic [31:0] d;} wr_t;
  typedef struct {int g; logic [12:0] a; logic [12:0] b;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  wr_t ww;
  rd_t rr;

  int ram[2][0:8191];
  int A[4][8];
  int Bm[8][4];
  int n_chk, n_fail;
  int nwr[2];

  always #5 clk = ~clk;

  function automatic int fm(int g); return (g == 0) ? 4 : 2; endfunction
  function automatic int fn(int g); return (g == 0) ? 4 : 2; endfunction
  function automatic int fk(int g); return (g == 0) ? 8 : 2; endfunction
  function automatic logic [12:0] fwb(int g); return (g == 0) ? 13'd0 : WB1; endfunction

  mm_ctrl u0 (
    .clk(clk), .rst(rst), .start(st[0]), .rd_en(rd[0]), .a_addr(aa[0]),
    .b_addr(ba[0]), .mac_clr(mclr[0]), .mac_en(men[0]), .sum(sum[0]),
    .web(web[0]), .w_addr(wa[0]), .dataRAM(dr[0]), .busy(busy[0]), .done(done[0])
  );

  mm_ctrl #(.M(2), .N(2), .K(2), .W_BASE(WB1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .rd_en(rd[1]), .a_addr(aa[1]),
    .b_addr(ba[1]), .mac_clr(mclr[1]), .mac_en(men[1]), .sum(sum[1]),
    .web(web[1]), .w_addr(wa[1]), .dataRAM(dr[1]), .busy(busy[1]), .done(done[1])
  );

  // Operand RAM with one-cycle read latency feeding a 20-bit accumulator.
  for (genvar g = 0; g < 2; g++) begin : g_acc
    int ad, bd;
    logic [19:0] acc;
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        ad <= 0; bd <= 0; acc <= '0;
      end else begin
        if (rd[g]) begin
          ad <= ram[g][aa[g]];
          bd <= ram[g][ba[g]];
        end
        if (mclr[g])     acc <= '0;
        else if (men[g]) acc <= 20'(acc + ad * bd);
      end
    end
    assign sum[g] = force_s[g] ? 20'hFFFFF : acc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // mode 0: identity A with B=[[1,2],[3,4]]; 1: all ones; 2: random bytes
  task automatic load(input int g, input int mode);
    for (int i = 0; i < fm(g); i++)
      for (int k = 0; k < fk(g); k++) begin
        A[i][k] = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(255)) : int'(i == k);
        ram[g][i * fk(g) + k] = A[i][k];
      end
    for (int k = 0; k < fk(g); k++)
      for (int j = 0; j < fn(g); j++) begin
        Bm[k][j] = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(255)) : k * 2 + j + 1;
        ram[g][64 + k * fn(g) + j] = Bm[k][j];
      end
  endtask

  task automatic push_exp(input int g, input bit frc);
    longint c;
    for (int i = 0; i < fm(g); i++)
      for (int j = 0; j < fn(g); j++) begin
        c = 0;
        for (int k = 0; k < fk(g); k++) begin
          c += A[i][k] * Bm[k][j];
          rq.push_back('{g, 13'(i * fk(g) + k), 13'(64 + k * fn(g) + j)});
        end
        wq.push_back('{g, 13'(fwb(g) + 4 * (i * fn(g) + j)),
                       frc ? 32'h000F_FFFF : {12'b0, c[19:0]}});
      end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int g = 0; g < 2; g++) begin
        if (rd[g] === 1'b1) begin
          if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_read inst=%0d a=%0h b=%0h", g, aa[g], ba[g]);
          end else begin
            rr = rq.pop_front();
            chk("read_instance", 64'(g), 64'(rr.g));
            chk("a_addr", 64'(aa[g]), 64'(rr.a));
            chk("b_addr", 64'(ba[g]), 64'(rr.b));
          end
        end
        if (web[g] === 1'b0) begin
          nwr[g]++;
          if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write inst=%0d addr=%0h data=%0h", g, wa[g], dr[g]);
          end else begin
            ww = wq.pop_front();
            chk("write_instance", 64'(g), 64'(ww.g));
            chk("w_addr", 64'(wa[g]), 64'(ww.a));
            chk("dataRAM", 64'(dr[g]), 64'(ww.d));
          end
        end
      end
    end
  end

  task automatic job(input int g, input bit frc, input bit hold);
    int cyc, exp_c;
    exp_c = fm(g) * fn(g) * (fk(g) + 3) + 1;
    force_s[g] = frc;
    push_exp(g, frc);
    if (hold) push_exp(g, frc);
    @(negedge clk);
    st[g] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (!hold) st[g] = 1'b0;
    end while (done[g] !== 1'b1 && cyc < 5000);
    chk("done_latency", 64'(cyc), 64'(exp_c));
    if (hold) begin
      @(posedge clk); #1;
      chk("idle_after_fin_busy", 64'(busy[g]), 64'd0);
      @(posedge clk); #1;
      chk("restart_busy", 64'(busy[g]), 64'd1);
      chk("restart_w_addr", 64'(wa[g]), 64'(fwb(g)));
      st[g] = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk); #1; cyc++;
      end while (done[g] !== 1'b1 && cyc < 5000);
      chk("done_latency_second", 64'(cyc), 64'(exp_c - 1));
    end
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy[g]), 64'd0);
    chk("done_one_cycle", 64'(done[g]), 64'd0);
    chk("scoreboard_drained", 64'(wq.size() + rq.size()), 64'd0);
    force_s[g] = 1'b0;
  endtask

  task automatic chk_reset_outs(input int g);
    chk("rst_web", 64'(web[g]), 64'd1);
    chk("rst_rd_en", 64'(rd[g]), 64'd0);
    chk("rst_mac_en", 64'(men[g]), 64'd0);
    chk("rst_mac_clr", 64'(mclr[g]), 64'd0);
    chk("rst_busy", 64'(busy[g]), 64'd0);
    chk("rst_done", 64'(done[g]), 64'd0);
    chk("rst_w_addr", 64'(wa[g]), 64'(fwb(g)));
    chk("rst_a_addr", 64'(aa[g]), 64'd0);
    chk("rst_b_addr", 64'(ba[g]), 64'd64);
  endtask

  initial begin
    int base, cyc;
    n_chk = 0; n_fail = 0;
    nwr[0] = 0; nwr[1] = 0;
    st[0] = 1'b0; st[1] = 1'b0;
    force_s[0] = 1'b0; force_s[1] = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    rst = 1'b1;
    @(negedge clk);

    load(1, 0); job(1, 0, 0);
    load(0, 1); job(0, 0, 0);
    repeat (2) begin load(0, 2); job(0, 0, 0); end
    load(0, 2); job(0, 1, 0);
    load(0, 2); job(0, 0, 1);

    // Abort a job during the READ phase of element 5.
    load(0, 2);
    push_exp(0, 1'b0);
    base = nwr[0];
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    cyc = 0;
    while (!(nwr[0] == base + 5 && rd[0] === 1'b1) && cyc < 2000) begin
      @(negedge clk); #1; cyc++;
    end
    chk("reached_element5", 64'(nwr[0] - base), 64'd5);
    #1 rst = 1'b0;
    #1 chk_reset_outs(0);
    wq.delete();
    rq.delete();
    @(negedge clk); rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_write_after_abort", 64'(nwr[0] - base), 64'd5);
    chk("idle_after_abort", 64'(busy[0]), 64'd0);

    load(0, 2); job(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
